// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - Y86-64 execute stage: ALU, condition evaluation and condition-code register
//
// Purpose: computes valE from the E-register fields, evaluates jump/cmov
// conditions against the current condition codes, cancels a failed cmov's
// writeback and updates {ZF,SF,OF} only when no exception is in flight.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   E_*_i               E pipeline register outputs (stat, icode, ifun, valC, valA, valB, dstE, dstM)
//   m_stat_i, W_stat_i  status of the instructions in memory and write-back
//   e_stat_o, e_icode_o, e_valA_o, e_dstM_o   pass-through of the E fields
//   e_valE_o            ALU result
//   e_dstE_o            E destination, NREG for a cmov whose condition fails
//   e_Cnd_o             condition result (JXX / RRMOVQ only)
//   cc_o                condition-code register {ZF,SF,OF}
module execute_stage #(
  parameter int DATA_W = 64,
  parameter int STAT_W = 3,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAT_W-1:0] E_stat_i,
  input  logic [3:0]        E_icode_i,
  input  logic [3:0]        E_ifun_i,
  input  logic [DATA_W-1:0] E_valC_i,
  input  logic [DATA_W-1:0] E_valA_i,
  input  logic [DATA_W-1:0] E_valB_i,
  input  logic [REG_W-1:0]  E_dstE_i,
  input  logic [REG_W-1:0]  E_dstM_i,
  input  logic [STAT_W-1:0] m_stat_i,
  input  logic [STAT_W-1:0] W_stat_i,
  output logic [STAT_W-1:0] e_stat_o,
  output logic [3:0]        e_icode_o,
  output logic [DATA_W-1:0] e_valE_o,
  output logic [DATA_W-1:0] e_valA_o,
  output logic [REG_W-1:0]  e_dstE_o,
  output logic [REG_W-1:0]  e_dstM_o,
  output logic              e_Cnd_o,
  output logic [2:0]        cc_o
);

  localparam logic [STAT_W-1:0] SAOK = STAT_W'(1);
  localparam logic [REG_W-1:0]  NREG = {REG_W{1'b1}};

  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] F_ADD = 4'h0;
  localparam logic [3:0] F_SUB = 4'h1;
  localparam logic [3:0] F_AND = 4'h2;
  localparam logic [3:0] F_XOR = 4'h3;

  localparam logic [DATA_W-1:0] EIGHT    = DATA_W'(8);
  localparam logic [2:0]        CC_RESET = 3'b100;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [3:0]        alufun;
  logic [DATA_W-1:0] alu_r;
  logic              new_zf;
  logic              new_sf;
  logic              new_of;
  logic              set_cc;
  logic              cnd;
  logic [2:0]        cc_d;
  logic [2:0]        cc_q;

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (E_icode_i)
      I_RRMOVQ, I_OPQ:              alu_a = E_valA_i;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC_i;
      I_CALL, I_PUSHQ:              alu_a = '0 - EIGHT;
      I_RET, I_POPQ:                alu_a = EIGHT;
      default:                      alu_a = '0;
    endcase
    case (E_icode_i)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_PUSHQ, I_RET, I_POPQ: alu_b = E_valB_i;
      default:                                                   alu_b = '0;
    endcase
  end

  // Only OPQ selects a function; address arithmetic and moves always add.
  assign alufun = (E_icode_i == I_OPQ) ? E_ifun_i : F_ADD;

  always_comb begin
    alu_r  = '0;
    new_of = 1'b0;
    case (alufun)
      F_ADD: begin
        alu_r  = alu_b + alu_a;
        new_of = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) && (alu_r[DATA_W-1] != alu_a[DATA_W-1]);
      end
      F_SUB: begin
        alu_r  = alu_b - alu_a;
        new_of = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) && (alu_r[DATA_W-1] != alu_b[DATA_W-1]);
      end
      F_AND:   alu_r = alu_b & alu_a;
      F_XOR:   alu_r = alu_b ^ alu_a;
      default: alu_r = '0;
    endcase
    new_zf = (alu_r == '0);
    new_sf = alu_r[DATA_W-1];
  end

  // Flags must not change behind an excepting instruction further down the pipe.
  assign set_cc = (E_icode_i == I_OPQ) && (E_ifun_i <= F_XOR) &&
                  (m_stat_i == SAOK) && (W_stat_i == SAOK) && (E_stat_i == SAOK);

  assign cc_d = set_cc ? {new_zf, new_sf, new_of} : cc_q;

  // Conditions read the registered flags, i.e. those left by earlier instructions.
  always_comb begin
    cnd = 1'b0;
    if (E_icode_i == I_JXX || E_icode_i == I_RRMOVQ) begin
      case (E_ifun_i)
        4'h0:    cnd = 1'b1;
        4'h1:    cnd = (cc_q[1] ^ cc_q[0]) | cc_q[2];
        4'h2:    cnd = cc_q[1] ^ cc_q[0];
        4'h3:    cnd = cc_q[2];
        4'h4:    cnd = ~cc_q[2];
        4'h5:    cnd = ~(cc_q[1] ^ cc_q[0]);
        4'h6:    cnd = ~(cc_q[1] ^ cc_q[0]) & ~cc_q[2];
        default: cnd = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_q <= CC_RESET;
    end else begin
      cc_q <= cc_d;
    end
  end

  assign e_stat_o  = E_stat_i;
  assign e_icode_o = E_icode_i;
  assign e_valE_o  = alu_r;
  assign e_valA_o  = E_valA_i;
  assign e_dstE_o  = (E_icode_i == I_RRMOVQ && !cnd) ? NREG : E_dstE_i;
  assign e_dstM_o  = E_dstM_i;
  assign e_Cnd_o   = cnd;
  assign cc_o      = cc_q;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - self-checking bench for execute_stage against a behavioural model
module tb_execute_stage;

  logic        clk;
  logic        rst;
  logic [2:0]  E_stat_i;
  logic [3:0]  E_icode_i;
  logic [3:0]  E_ifun_i;
  logic [63:0] E_valC_i;
  logic [63:0] E_valA_i;
  logic [63:0] E_valB_i;
  logic [3:0]  E_dstE_i;
  logic [3:0]  E_dstM_i;
  logic [2:0]  m_stat_i;
  logic [2:0]  W_stat_i;
  logic [2:0]  e_stat_o;
  logic [3:0]  e_icode_o;
  logic [63:0] e_valE_o;
  logic [63:0] e_valA_o;
  logic [3:0]  e_dstE_o;
  logic [3:0]  e_dstM_o;
  logic        e_Cnd_o;
  logic [2:0]  cc_o;

  int          passed;
  int          total;
  logic [2:0]  mcc;
  logic [63:0] last_vale;
  logic        last_cnd;
  logic [3:0]  last_dste;

  execute_stage #(.DATA_W(64), .STAT_W(3), .REG_W(4)) dut (
    .clk(clk), .rst(rst),
    .E_stat_i(E_stat_i), .E_icode_i(E_icode_i), .E_ifun_i(E_ifun_i),
    .E_valC_i(E_valC_i), .E_valA_i(E_valA_i), .E_valB_i(E_valB_i),
    .E_dstE_i(E_dstE_i), .E_dstM_i(E_dstM_i),
    .m_stat_i(m_stat_i), .W_stat_i(W_stat_i),
    .e_stat_o(e_stat_o), .e_icode_o(e_icode_o), .e_valE_o(e_valE_o),
    .e_valA_o(e_valA_o), .e_dstE_o(e_dstE_o), .e_dstM_o(e_dstM_o),
    .e_Cnd_o(e_Cnd_o), .cc_o(cc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Reference: operands as signed integers, overflow judged by whether the
  // exact (65-bit) result fits in 64 bits.
  task automatic model(input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] vc, input logic [63:0] va, input logic [63:0] vb,
                       input logic [2:0] es, input logic [2:0] ms, input logic [2:0] ws,
                       input logic [2:0] cc_now,
                       output logic [63:0] r, output logic cnd, output logic set,
                       output logic [2:0] flags);
    logic [63:0] a;
    logic [63:0] b;
    logic signed [64:0] wide;
    logic of;
    logic z;
    logic s;
    logic o;
    a = 64'd0;
    b = 64'd0;
    if (ic == 4'h2 || ic == 4'h6) a = va;
    else if (ic == 4'h3 || ic == 4'h4 || ic == 4'h5) a = vc;
    else if (ic == 4'h8 || ic == 4'hA) a = -64'sd8;
    else if (ic == 4'h9 || ic == 4'hB) a = 64'd8;
    if (ic == 4'h4 || ic == 4'h5 || (ic >= 4'h6 && ic <= 4'hB && ic != 4'h7)) b = vb;
    of = 1'b0;
    if (ic == 4'h6 && fn == 4'd1) begin
      wide = $signed({b[63], b}) - $signed({a[63], a});
      r = wide[63:0];
      of = (wide[64] != wide[63]);
    end else if (ic == 4'h6 && fn == 4'd2) r = a & b;
    else if (ic == 4'h6 && fn == 4'd3) r = a ^ b;
    else if (ic == 4'h6 && fn > 4'd3) r = 64'd0;
    else begin
      wide = $signed({b[63], b}) + $signed({a[63], a});
      r = wide[63:0];
      of = (wide[64] != wide[63]);
    end
    flags = {r == 64'd0, r[63], of};
    set = (ic == 4'h6) && (fn <= 4'd3) && es == 3'd1 && ms == 3'd1 && ws == 3'd1;
    z = cc_now[2];
    s = cc_now[1];
    o = cc_now[0];
    cnd = 1'b0;
    if (ic == 4'h7 || ic == 4'h2) begin
      case (fn)
        4'd0: cnd = 1'b1;
        4'd1: cnd = (s != o) || z;
        4'd2: cnd = (s != o);
        4'd3: cnd = z;
        4'd4: cnd = !z;
        4'd5: cnd = (s == o);
        4'd6: cnd = (s == o) && !z;
        default: cnd = 1'b0;
      endcase
    end
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] vc,
                       input logic [63:0] va, input logic [63:0] vb, input logic [3:0] de,
                       input logic [3:0] dm, input logic [2:0] es, input logic [2:0] ms,
                       input logic [2:0] ws);
    E_icode_i = ic; E_ifun_i = fn; E_valC_i = vc; E_valA_i = va; E_valB_i = vb;
    E_dstE_i = de; E_dstM_i = dm; E_stat_i = es; m_stat_i = ms; W_stat_i = ws;
  endtask

  // One instruction: check combinational outputs mid-cycle, then cc after the edge.
  task automatic step(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] vc,
                      input logic [63:0] va, input logic [63:0] vb, input logic [3:0] de,
                      input logic [3:0] dm, input logic [2:0] es, input logic [2:0] ms,
                      input logic [2:0] ws);
    logic [63:0] r;
    logic cnd;
    logic set;
    logic [2:0] fl;
    drive(ic, fn, vc, va, vb, de, dm, es, ms, ws);
    #2;
    model(ic, fn, vc, va, vb, es, ms, ws, mcc, r, cnd, set, fl);
    check("valE", e_valE_o, r);
    check("Cnd", {63'd0, e_Cnd_o}, {63'd0, cnd});
    check("dstE", {60'd0, e_dstE_o}, {60'd0, (ic == 4'h2 && !cnd) ? 4'hF : de});
    check("pass", {e_stat_o, e_icode_o, e_dstM_o, e_valA_o[15:0]}, {es, ic, dm, va[15:0]});
    last_vale = e_valE_o;
    last_cnd  = e_Cnd_o;
    last_dste = e_dstE_o;
    if (set) mcc = fl;
    @(posedge clk);
    #1;
    check("cc", {61'd0, cc_o}, {61'd0, mcc});
  endtask

  function automatic logic [63:0] rand_word();
    logic [63:0] w;
    case ($urandom_range(0, 5))
      0: w = 64'd0;
      1: w = 64'h7FFF_FFFF_FFFF_FFFF;
      2: w = 64'h8000_0000_0000_0000;
      3: w = 64'hFFFF_FFFF_FFFF_FFFF;
      default: w = {$urandom, $urandom};
    endcase
    return w;
  endfunction

  function automatic logic [2:0] rand_stat();
    return ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 4)) : 3'd1;
  endfunction

  initial begin
    passed = 0;
    total  = 0;
    mcc    = 3'b100;
    rst    = 1'b1;
    drive(4'h0, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 3'd1, 3'd1, 3'd1);
    #12;
    check("reset_cc", {61'd0, cc_o}, 64'd4);
    check("idle_valE", e_valE_o, 64'd0);
    check("idle_Cnd", {63'd0, e_Cnd_o}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed cases
    step(4'h6, 4'h0, 64'd0, 64'd3, 64'd5, 4'h1, 4'hF, 3'd1, 3'd1, 3'd1);
    check("t1_valE", last_vale, 64'd8);
    check("t1_cc", {61'd0, cc_o}, 64'd0);
    step(4'h6, 4'h1, 64'd0, 64'd5, 64'd5, 4'h1, 4'hF, 3'd1, 3'd1, 3'd1);
    check("t2a_valE", last_vale, 64'd0);
    check("t2a_cc", {61'd0, cc_o}, 64'd4);
    step(4'h6, 4'h1, 64'd0, 64'd1, 64'd0, 4'h1, 4'hF, 3'd1, 3'd1, 3'd1);
    check("t2b_valE", last_vale, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t2b_cc", {61'd0, cc_o}, 64'd2);
    step(4'h6, 4'h0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'h1, 4'hF, 3'd1, 3'd1, 3'd1);
    check("t3_valE", last_vale, 64'hFFFF_FFFF_FFFF_FFFE);
    check("t3_cc", {61'd0, cc_o}, 64'd3);
    step(4'h7, 4'h2, 64'h40, 64'd0, 64'd0, 4'hF, 4'hF, 3'd1, 3'd1, 3'd1);
    check("t3_jl", {63'd0, last_cnd}, 64'd0);
    step(4'h6, 4'h1, 64'd0, 64'd5, 64'd5, 4'h1, 4'hF, 3'd1, 3'd1, 3'd1);
    step(4'h2, 4'h4, 64'd0, 64'd7, 64'd0, 4'h3, 4'hF, 3'd1, 3'd1, 3'd1);
    check("t4_ne_cnd", {63'd0, last_cnd}, 64'd0);
    check("t4_ne_dst", {60'd0, last_dste}, 64'hF);
    step(4'h2, 4'h3, 64'd0, 64'd7, 64'd0, 4'h3, 4'hF, 3'd1, 3'd1, 3'd1);
    check("t4_e_cnd", {63'd0, last_cnd}, 64'd1);
    check("t4_e_dst", {60'd0, last_dste}, 64'd3);
    step(4'h6, 4'h1, 64'd0, 64'd1, 64'd0, 4'h1, 4'hF, 3'd1, 3'd1, 3'd1);
    step(4'h6, 4'h3, 64'd0, 64'd9, 64'd9, 4'h1, 4'hF, 3'd1, 3'd3, 3'd1);
    check("t5_m_valE", last_vale, 64'd0);
    check("t5_m_cc", {61'd0, cc_o}, 64'd2);
    step(4'h6, 4'h3, 64'd0, 64'd9, 64'd9, 4'h1, 4'hF, 3'd1, 3'd1, 3'd2);
    check("t5_w_cc", {61'd0, cc_o}, 64'd2);
    step(4'hA, 4'h0, 64'd0, 64'd0, 64'h100, 4'h4, 4'hF, 3'd1, 3'd1, 3'd1);
    check("t6_push", last_vale, 64'hF8);
    step(4'hB, 4'h0, 64'd0, 64'd0, 64'h100, 4'h4, 4'h2, 3'd1, 3'd1, 3'd1);
    check("t6_pop", last_vale, 64'h108);
    step(4'h5, 4'h0, 64'h10, 64'd0, 64'h20, 4'hF, 4'h2, 3'd1, 3'd1, 3'd1);
    check("t6_mrmov", last_vale, 64'h30);
    step(4'h6, 4'h7, 64'd0, 64'd5, 64'd9, 4'h1, 4'hF, 3'd1, 3'd1, 3'd1);
    check("bad_opq_valE", last_vale, 64'd0);

    // Asynchronous reset mid-stream, with a flag update pending on the same edge
    step(4'h6, 4'h0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'h1, 4'hF, 3'd1, 3'd1, 3'd1);
    drive(4'h6, 4'h1, 64'd0, 64'd1, 64'd0, 4'h1, 4'hF, 3'd1, 3'd1, 3'd1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_cc", {61'd0, cc_o}, 64'd4);
    @(posedge clk);
    #1;
    check("rst_edge_cc", {61'd0, cc_o}, 64'd4);
    rst = 1'b0;
    mcc = 3'b100;

    // Randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      step(4'($urandom_range(0, 11)), 4'($urandom_range(0, 7)), rand_word(), rand_word(),
           rand_word(), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           rand_stat(), rand_stat(), rand_stat());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
